lpc_rd_mux_pipe: RTL and testbench

//  Parametrised LPC register read-back multiplexer with a request/acknowledge handshake.
//  - Sits in the Lpc hierarchy between the LPC cycle decoder and the register bank.
//  - Returns register data, a live BIOS status byte, and a clear-on-read sticky event register.
//  - Flags out-of-range reads with an error output.
//  - Fixed 2-cycle latency, with one read in flight at a time.

---
 rtl/lpc_pkg.sv | 18 +
 rtl/lpc_sticky_reg.sv | 32 +++
 rtl/lpc_rd_mux_pipe.sv | 159 +++++++++++++++
 tb/tb_lpc_rd_mux_pipe.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/lpc_pkg.sv
// Shared definitions for the Lpc register read-back path: FSM encoding, default widths
// and the special read addresses.
package lpc_pkg;

    typedef enum logic [1:0] {
        LRM_IDLE,
        LRM_LOOKUP,
        LRM_RESP
    } lrm_state_t;

    localparam int LPC_DATA_W = 8;
    localparam int LPC_ADDR_W = 8;

    localparam logic [LPC_ADDR_W-1:0] LPC_STATUS_ADDR = 8'h04;
    localparam logic [LPC_ADDR_W-1:0] LPC_EVENT_ADDR  = 8'h05;
    localparam logic [LPC_ADDR_W-1:0] LPC_ERRCNT_ADDR = 8'h06;

endpackage

// File: rtl/lpc_sticky_reg.sv
// Set-dominant clear-on-read event register: each bit latches its event pulse until a clear,
// and a pulse arriving in the clear cycle survives it.
module lpc_sticky_reg
    import lpc_pkg::*;
#(
    parameter int WIDTH = LPC_DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] set_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] value_o
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    always_comb begin
        value_d = (clr_i ? '0 : value_q) | set_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/lpc_rd_mux_pipe.sv
// LPC register read-back mux: IDLE/LOOKUP/RESP pipeline returning register data, BIOS status
// or a sticky event register. Optional error counter enabled by LPC_RD_ERRCNT_EN.
module lpc_rd_mux_pipe
    import lpc_pkg::*;
#(
    parameter int                NUM_REGS     = 32,
    parameter int                DATA_W       = LPC_DATA_W,
    parameter int                ADDR_W       = LPC_ADDR_W,
    parameter int                STATUS_W     = 3,
    parameter logic [ADDR_W-1:0] STATUS_ADDR  = ADDR_W'(LPC_STATUS_ADDR),
    parameter logic [ADDR_W-1:0] EVENT_ADDR   = ADDR_W'(LPC_EVENT_ADDR),
`ifdef LPC_RD_ERRCNT_EN
    parameter logic [ADDR_W-1:0] ERRCNT_ADDR  = ADDR_W'(LPC_ERRCNT_ADDR),
`endif
    parameter logic [DATA_W-1:0] DEFAULT_DATA = '0
) (
    input  logic                LpcClock,
    input  logic                PciReset,
    input  logic                RdReq,
    input  logic [ADDR_W-1:0]   AddrReg,
    input  logic [DATA_W-1:0]   DataReg [NUM_REGS],
    input  logic [STATUS_W-1:0] BiosStatus,
    input  logic [DATA_W-1:0]   EventIn,
    output logic [DATA_W-1:0]   DataRd,
    output logic                RdAck,
    output logic                RdErr,
    output logic                Busy
);

    localparam int                IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

    lrm_state_t          state_q;
    lrm_state_t          state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   data_rd_q;
    logic [DATA_W-1:0]   data_rd_d;
    logic                rd_err_q;
    logic                rd_err_d;

    logic                is_lookup;
    logic                in_range;
    logic [DATA_W-1:0]   status_ext;
    logic [DATA_W-1:0]   mux_data;
    logic                mux_err;
    logic                event_clr;
    logic [DATA_W-1:0]   event_value;

`ifdef LPC_RD_ERRCNT_EN
    logic [DATA_W-1:0]   errcnt_q;
    logic [DATA_W-1:0]   errcnt_d;
    logic                errcnt_clr;
`endif

    assign is_lookup = (state_q == LRM_LOOKUP);
    assign in_range  = ({1'b0, addr_q} < NUM_REGS_W);

    lpc_sticky_reg #(
        .WIDTH (DATA_W)
    ) u_event_reg (
        .clk     (LpcClock),
        .rst_n   (PciReset),
        .set_i   (EventIn),
        .clr_i   (event_clr),
        .value_o (event_value)
    );

    // Special addresses take priority over the bank, even when they fall outside it.
    always_comb begin
        status_ext                 = '0;
        status_ext[STATUS_W-1:0]   = BiosStatus;
        mux_data                   = DEFAULT_DATA;
        mux_err                    = 1'b0;
        event_clr                  = 1'b0;
`ifdef LPC_RD_ERRCNT_EN
        errcnt_clr                 = 1'b0;
`endif
        if (addr_q == STATUS_ADDR) begin
            mux_data = status_ext;
        end else if (addr_q == EVENT_ADDR) begin
            mux_data  = event_value;
            event_clr = is_lookup;
`ifdef LPC_RD_ERRCNT_EN
        end else if (addr_q == ERRCNT_ADDR) begin
            mux_data   = errcnt_q;
            errcnt_clr = is_lookup;
`endif
        end else if (in_range) begin
            mux_data = DataReg[addr_q[IDX_W-1:0]];
        end else begin
            mux_err = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_rd_d = data_rd_q;
        rd_err_d  = rd_err_q;
        case (state_q)
            LRM_IDLE: begin
                if (RdReq) begin
                    state_d = LRM_LOOKUP;
                    addr_d  = AddrReg;
                end
            end
            LRM_LOOKUP: begin
                state_d   = LRM_RESP;
                data_rd_d = mux_data;
                rd_err_d  = mux_err;
            end
            LRM_RESP: begin
                state_d = LRM_IDLE;
            end
            default: begin
                state_d = LRM_IDLE;
            end
        endcase
    end

    always_ff @(posedge LpcClock) begin
        if (!PciReset) begin
            state_q   <= LRM_IDLE;
            addr_q    <= '0;
            data_rd_q <= '0;
            rd_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_rd_q <= data_rd_d;
            rd_err_q  <= rd_err_d;
        end
    end

`ifdef LPC_RD_ERRCNT_EN
    // Clear first so an error landing in the clear cycle restarts the count at one.
    always_comb begin
        errcnt_d = errcnt_clr ? '0 : errcnt_q;
        if (is_lookup && mux_err && (errcnt_d != '1)) begin
            errcnt_d = errcnt_d + DATA_W'(1);
        end
    end

    always_ff @(posedge LpcClock) begin
        if (!PciReset) begin
            errcnt_q <= '0;
        end else begin
            errcnt_q <= errcnt_d;
        end
    end
`endif

    assign DataRd = data_rd_q;
    assign RdErr  = rd_err_q;
    assign RdAck  = (state_q == LRM_RESP);
    assign Busy   = (state_q != LRM_IDLE);

endmodule

// File: tb/tb_lpc_rd_mux_pipe.sv
// Directed bench for lpc_rd_mux_pipe: table of single reads plus hand-written sequences for
// sticky clearing, held requests, mid-transaction reset and (if LPC_RD_ERRCNT_EN) the counter.
module tb_lpc_rd_mux_pipe;

    typedef struct {
        string      name;
        logic [7:0] addr;
        logic [2:0] status;
        logic [7:0] exp_data;
        logic       exp_err;
    } rd_vec_t;

    logic       lpc_clock;
    logic       pci_reset;
    logic       rd_req;
    logic [7:0] addr_reg;
    logic [7:0] data_reg [32];
    logic [2:0] bios_status;
    logic [7:0] event_in;
    logic [7:0] data_rd;
    logic       rd_ack;
    logic       rd_err;
    logic       busy;

    int n_compared;
    int n_mismatched;

    lpc_rd_mux_pipe dut (
        .LpcClock   (lpc_clock),
        .PciReset   (pci_reset),
        .RdReq      (rd_req),
        .AddrReg    (addr_reg),
        .DataReg    (data_reg),
        .BiosStatus (bios_status),
        .EventIn    (event_in),
        .DataRd     (data_rd),
        .RdAck      (rd_ack),
        .RdErr      (rd_err),
        .Busy       (busy)
    );

    initial lpc_clock = 1'b0;
    always #5 lpc_clock = ~lpc_clock;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Starts just after a rising edge; one full read takes four edges and ends likewise.
    task automatic apply_stimulus(input string name, input logic [7:0] addr,
                                  input logic [2:0] status, input logic [7:0] ev_lookup,
                                  input logic [7:0] exp_data, input logic exp_err,
                                  input bit check);
        rd_req      = 1'b1;
        addr_reg    = addr;
        bios_status = status;
        @(posedge lpc_clock);
        #1;
        rd_req   = 1'b0;
        addr_reg = 8'hEE;
        event_in = ev_lookup;
        @(negedge lpc_clock);
        if (check) begin
            check_output({name, ".busy_lookup"}, 32'(busy), 32'd1);
            check_output({name, ".ack_lookup"}, 32'(rd_ack), 32'd0);
        end
        @(posedge lpc_clock);
        #1;
        event_in    = 8'h00;
        bios_status = ~status;
        @(negedge lpc_clock);
        if (check) begin
            check_output({name, ".ack"}, 32'(rd_ack), 32'd1);
            check_output({name, ".data"}, 32'(data_rd), 32'(exp_data));
            check_output({name, ".err"}, 32'(rd_err), 32'(exp_err));
        end
        @(posedge lpc_clock);
        @(negedge lpc_clock);
        if (check) begin
            check_output({name, ".ack_idle"}, 32'(rd_ack), 32'd0);
            check_output({name, ".busy_idle"}, 32'(busy), 32'd0);
            check_output({name, ".data_held"}, 32'(data_rd), 32'(exp_data));
        end
        @(posedge lpc_clock);
        #1;
    endtask

    initial begin
        rd_vec_t    vecs[$];
        logic [7:0] ack_seen;

        n_compared   = 0;
        n_mismatched = 0;
        pci_reset    = 1'b0;
        rd_req       = 1'b0;
        addr_reg     = 8'h00;
        bios_status  = 3'b000;
        event_in     = 8'h00;
        for (int i = 0; i < 32; i++) begin
            data_reg[i] = {4'(i), ~4'(i)};
        end
        data_reg[3] = 8'hA5;

        vecs.push_back('{"plain_3",   8'h03, 3'b000, 8'hA5, 1'b0});
        vecs.push_back('{"reg_0",     8'h00, 3'b000, 8'h0F, 1'b0});
        vecs.push_back('{"reg_last",  8'h1F, 3'b000, 8'hF0, 1'b0});
        vecs.push_back('{"status_5",  8'h04, 3'b101, 8'h05, 1'b0});
        vecs.push_back('{"status_2",  8'h04, 3'b010, 8'h02, 1'b0});
        vecs.push_back('{"sticky_rst",8'h05, 3'b000, 8'h00, 1'b0});
        vecs.push_back('{"oor_40",    8'h40, 3'b000, 8'h00, 1'b1});
        vecs.push_back('{"oor_20",    8'h20, 3'b000, 8'h00, 1'b1});
        vecs.push_back('{"oor_ff",    8'hFF, 3'b000, 8'h00, 1'b1});
        vecs.push_back('{"reg_2",     8'h02, 3'b000, 8'h2D, 1'b0});
`ifndef LPC_RD_ERRCNT_EN
        vecs.push_back('{"reg_6",     8'h06, 3'b000, 8'h69, 1'b0});
`endif

        // Reset held for two edges.
        @(posedge lpc_clock);
        @(posedge lpc_clock);
        @(negedge lpc_clock);
        check_output("rst.data", 32'(data_rd), 32'd0);
        check_output("rst.ack", 32'(rd_ack), 32'd0);
        check_output("rst.err", 32'(rd_err), 32'd0);
        check_output("rst.busy", 32'(busy), 32'd0);
        pci_reset = 1'b1;
        @(posedge lpc_clock);
        #1;

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].name, vecs[i].addr, vecs[i].status, 8'h00,
                           vecs[i].exp_data, vecs[i].exp_err, 1'b1);
        end

        // Sticky: pulse 0x81, then read with 0x02 arriving in the clear cycle.
        event_in = 8'h81;
        @(posedge lpc_clock);
        #1;
        event_in = 8'h00;
        apply_stimulus("ev_first",   8'h05, 3'b000, 8'h02, 8'h81, 1'b0, 1'b1);
        apply_stimulus("ev_setwins", 8'h05, 3'b000, 8'h00, 8'h02, 1'b0, 1'b1);
        apply_stimulus("ev_cleared", 8'h05, 3'b000, 8'h00, 8'h00, 1'b0, 1'b1);

        // RdReq held high: acks expected after the 2nd and 5th edges only.
        rd_req   = 1'b1;
        addr_reg = 8'h03;
        ack_seen = 8'h00;
        for (int i = 1; i <= 8; i++) begin
            @(posedge lpc_clock);
            if (i == 6) begin
                #1;
                rd_req = 1'b0;
            end
            @(negedge lpc_clock);
            ack_seen[i-1] = rd_ack;
        end
        check_output("held.ack_pattern", 32'(ack_seen), 32'h12);
        check_output("held.data", 32'(data_rd), 32'hA5);
        @(posedge lpc_clock);
        #1;

        // Reset asserted during LOOKUP drops the read.
        rd_req   = 1'b1;
        addr_reg = 8'h1F;
        @(posedge lpc_clock);
        #1;
        rd_req    = 1'b0;
        pci_reset = 1'b0;
        @(posedge lpc_clock);
        @(negedge lpc_clock);
        check_output("midrst.busy", 32'(busy), 32'd0);
        check_output("midrst.ack", 32'(rd_ack), 32'd0);
        check_output("midrst.data", 32'(data_rd), 32'd0);
        pci_reset = 1'b1;
        @(negedge lpc_clock);
        check_output("midrst.ack_after", 32'(rd_ack), 32'd0);
        check_output("midrst.busy_after", 32'(busy), 32'd0);
        @(posedge lpc_clock);
        #1;
        apply_stimulus("post_rst", 8'h03, 3'b000, 8'h00, 8'hA5, 1'b0, 1'b1);

`ifdef LPC_RD_ERRCNT_EN
        apply_stimulus("cnt_flush", 8'h06, 3'b000, 8'h00, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus("cnt_err", 8'h40, 3'b000, 8'h00, 8'h00, 1'b1, 1'b1);
        end
        apply_stimulus("cnt_three", 8'h06, 3'b000, 8'h00, 8'h03, 1'b0, 1'b1);
        apply_stimulus("cnt_zero",  8'h06, 3'b000, 8'h00, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 256; i++) begin
            apply_stimulus("cnt_sat_err", 8'h80, 3'b000, 8'h00, 8'h00, 1'b1, 1'b0);
        end
        apply_stimulus("cnt_sat", 8'h06, 3'b000, 8'h00, 8'hFF, 1'b0, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
